// File: rtl/pnseq_sample_framer_pkg.sv
// Shared types and helpers for the PN sample framer.
// Optional feature macro: PNSEQ_FRAMER_GUARD_EN (adds the GUARD state).
package pnseq_pkg;

`ifdef PNSEQ_FRAMER_GUARD_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GUARD,
    ST_FLUSH
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FLUSH
  } state_t;
`endif

  // Standard sounder sequence length (order-6 m-sequence).
  localparam int unsigned PN_LEN_63 = 63;

  // Widest sample component the mapping helper supports.
  localparam int unsigned SAMP_W_MAX = 32;

  // BPSK mapping: chip 1 -> +amp, chip 0 -> -amp (two's complement).
  // Callers pass a zero-extended amplitude and truncate the result to
  // their own sample width; negation survives truncation unchanged.
  function automatic logic [SAMP_W_MAX-1:0] bpsk_map(input logic chip,
                                                     input logic [SAMP_W_MAX-1:0] amp);
    return chip ? amp : (~amp + SAMP_W_MAX'(1));
  endfunction

endpackage

// File: rtl/pnseq_sample_framer_if.sv
// AXI-Stream sample bus between the framer and its consumer.
interface pnseq_sample_framer_if #(
  parameter int unsigned SAMP_W = 16
);
  logic [2*SAMP_W-1:0] tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pnseq_sample_framer_outreg.sv
// Single-entry AXI-Stream output register. 'load' must only be raised
// while 'can_load' is high; the held beat stays stable until accepted.
module pnseq_axis_outreg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  output logic         can_load,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         tlast,
  input  logic         tready
);

  assign can_load = !tvalid || tready;

  // Hold register: refill on load, drop valid once the beat is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/pnseq_sample_framer.sv
// PN chip sequencer and BPSK AXI-Stream framer.
// Optional feature macro: PNSEQ_FRAMER_GUARD_EN (zero-sample guard between
// sequences, adds cfg_guard input).
module pnseq_sample_framer
  import pnseq_pkg::*;
#(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned SAMP_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [LEN_W-1:0]   cfg_seq_len,
  input  logic [LEN_W-1:0]   cfg_num_seq,
  input  logic [SAMP_W-1:0]  cfg_amp,
`ifdef PNSEQ_FRAMER_GUARD_EN
  input  logic [LEN_W-1:0]   cfg_guard,
`endif
  output logic               lfsr_load,
  output logic               lfsr_en,
  input  logic               pnseq,
  pnseq_sample_framer_if.master m_axis,
  output logic               busy,
  output logic               done
);

  localparam logic [SAMP_W-1:0] AMP_MASK = {1'b0, {(SAMP_W-1){1'b1}}};

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    seq_len_q, num_seq_q, chip_cnt_q, rep_cnt_q;
  logic [SAMP_W-1:0]   amp_q;
  logic                stop_pend_q;
  logic                done_q;
`ifdef PNSEQ_FRAMER_GUARD_EN
  logic [LEN_W-1:0]    guard_q, guard_cnt_q;
  logic                guard_last;
`endif

  logic                start_ok, last_chip, final_seq, stop_now;
  logic                ld, ld_last, can_load;
  logic [2*SAMP_W-1:0] ld_data;
  logic [SAMP_W-1:0]   i_val;
  logic [2*SAMP_W-1:0] axis_tdata;
  logic                axis_tvalid, axis_tlast;

  assign start_ok  = cfg_start && (cfg_seq_len != '0);
  assign last_chip = (chip_cnt_q == seq_len_q - LEN_W'(1));
  assign final_seq = (num_seq_q != '0) && (rep_cnt_q == num_seq_q - LEN_W'(1));
  assign stop_now  = stop_pend_q || cfg_stop;
  assign i_val     = SAMP_W'(bpsk_map(pnseq, SAMP_W_MAX'(amp_q)));
`ifdef PNSEQ_FRAMER_GUARD_EN
  assign guard_last = (guard_cnt_q == guard_q - LEN_W'(1));
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, LFSR control and output-register load.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    ld        = 1'b0;
    ld_last   = 1'b0;
    ld_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        lfsr_load = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (can_load) begin
          ld      = 1'b1;
          lfsr_en = 1'b1;
          ld_data = {i_val, {SAMP_W{1'b0}}};
          ld_last = last_chip;
          if (last_chip) begin
            if (final_seq || stop_now) state_d = ST_FLUSH;
`ifdef PNSEQ_FRAMER_GUARD_EN
            else if (guard_q != '0)    state_d = ST_GUARD;
`endif
            else                       state_d = ST_LOAD;
          end
        end
      end
`ifdef PNSEQ_FRAMER_GUARD_EN
      ST_GUARD: begin
        if (can_load) begin
          ld = 1'b1;
          if (guard_last) state_d = ST_LOAD;
        end
      end
`endif
      ST_FLUSH: begin
        if (axis_tvalid && m_axis.tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config latch, chip/rep counters, sticky stop and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_len_q   <= '0;
      num_seq_q   <= '0;
      amp_q       <= '0;
      chip_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PNSEQ_FRAMER_GUARD_EN
      guard_q     <= '0;
      guard_cnt_q <= '0;
`endif
    end else begin
      done_q <= (state_q == ST_FLUSH) && (state_d == ST_IDLE);

      if (state_q == ST_IDLE) stop_pend_q <= 1'b0;
      else if (cfg_stop)      stop_pend_q <= 1'b1;

      if (state_q == ST_IDLE && start_ok) begin
        seq_len_q  <= cfg_seq_len;
        num_seq_q  <= cfg_num_seq;
        amp_q      <= cfg_amp & AMP_MASK;
        chip_cnt_q <= '0;
        rep_cnt_q  <= '0;
`ifdef PNSEQ_FRAMER_GUARD_EN
        guard_q     <= cfg_guard;
        guard_cnt_q <= '0;
`endif
      end

      if (state_q == ST_RUN && can_load) begin
        chip_cnt_q <= last_chip ? '0 : chip_cnt_q + LEN_W'(1);
        if (last_chip && !(final_seq || stop_now))
          rep_cnt_q <= rep_cnt_q + LEN_W'(1);
      end

`ifdef PNSEQ_FRAMER_GUARD_EN
      if (state_q == ST_GUARD && can_load)
        guard_cnt_q <= guard_last ? '0 : guard_cnt_q + LEN_W'(1);
`endif
    end
  end

  pnseq_axis_outreg #(
    .W (2*SAMP_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_data (ld_data),
    .load_last (ld_last),
    .can_load  (can_load),
    .tdata     (axis_tdata),
    .tvalid    (axis_tvalid),
    .tlast     (axis_tlast),
    .tready    (m_axis.tready)
  );

  assign m_axis.tdata  = axis_tdata;
  assign m_axis.tvalid = axis_tvalid;
  assign m_axis.tlast  = axis_tlast;

endmodule

// File: tb/tb_pnseq_sample_framer.sv
// Self-checking bench for pnseq_sample_framer with an order-6 LFSR stand-in.
module tb_pnseq_sample_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [15:0] cfg_seq_len = '0, cfg_num_seq = '0, cfg_amp = '0, cfg_guard = '0;
  logic        lfsr_load, lfsr_en, pnseq, busy, done;
  logic [5:0]  lfsr_s = 6'b000001;

  pnseq_sample_framer_if #(.SAMP_W(16)) axis ();

  pnseq_sample_framer #(
    .LEN_W  (16),
    .SAMP_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_seq_len (cfg_seq_len),
    .cfg_num_seq (cfg_num_seq),
    .cfg_amp     (cfg_amp),
`ifdef PNSEQ_FRAMER_GUARD_EN
    .cfg_guard   (cfg_guard),
`endif
    .lfsr_load   (lfsr_load),
    .lfsr_en     (lfsr_en),
    .pnseq       (pnseq),
    .m_axis      (axis),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // External PN generator: x^6+x^5+1, seed 000001, chip = MSB.
  assign pnseq = lfsr_s[5];
  always @(posedge clk) begin
    if (lfsr_load)    lfsr_s <= 6'b000001;
    else if (lfsr_en) lfsr_s <= {lfsr_s[4:0], lfsr_s[5] ^ lfsr_s[4]};
  end

  int ready_pct = 100;
  always @(posedge clk) begin
    #1 axis.tready = ($urandom_range(0, 99) < ready_pct);
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference m-sequence from the recurrence a[n+6] = a[n] ^ a[n+1].
  logic pn [0:199];
  initial begin
    for (int n = 0; n < 6; n++) pn[n] = (n == 5);
    for (int n = 6; n < 200; n++) pn[n] = pn[n-6] ^ pn[n-5];
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        bubble;
  } item_t;
  item_t exp_q[$];

  int   hs_cnt = 0, done_cnt = 0, en_cnt = 0, ld_cnt = 0;
  logic first_hs = 1'b1;

  // Compare process: every cycle the stream and control outputs are meaningful.
  int          cyc = 0, last_hs_cyc = 0;
  logic        prev_bubble = 1'b0, expect_done = 1'b0, stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  always @(negedge clk) begin
    item_t it;
    cyc++;
    if (!rst) begin
      expect_done = 1'b0;
      stall_prev  = 1'b0;
    end else begin
      if (lfsr_en)   en_cnt++;
      if (lfsr_load) ld_cnt++;
      if (lfsr_en || lfsr_load) check("en_load_overlap", 64'(lfsr_en & lfsr_load), 0);
      if (expect_done) begin
        check("done_pulse", 64'(done), 1);
        check("busy_fall", 64'(busy), 0);
        done_cnt++;
        expect_done = 1'b0;
      end else if (done) begin
        check("spurious_done", 64'(done), 0);
      end
      if (stall_prev) begin
        check("stall_tvalid", 64'(axis.tvalid), 1);
        check("stall_tdata", 64'(axis.tdata), 64'(stall_data));
        check("stall_tlast", 64'(axis.tlast), 64'(stall_last));
      end
      if (axis.tvalid && !axis.tready) check("stall_lfsr_en", 64'(lfsr_en), 0);
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_sample: got %0h expected no sample at %0t", axis.tdata, $time);
        end else begin
          it = exp_q.pop_front();
          check("tdata", 64'(axis.tdata), 64'(it.data));
          check("tlast", 64'(axis.tlast), 64'(it.last));
          if (ready_pct == 100 && !first_hs)
            check("gap", 64'(cyc - last_hs_cyc), prev_bubble ? 64'd2 : 64'd1);
          first_hs    = 1'b0;
          last_hs_cyc = cyc;
          prev_bubble = it.bubble;
          hs_cnt++;
          if (exp_q.size() == 0) expect_done = 1'b1;
        end
      end
      stall_prev = axis.tvalid && !axis.tready;
      stall_data = axis.tdata;
      stall_last = axis.tlast;
    end
  end

  task automatic wait_hs(input int base, input int n);
    int k;
    for (k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (hs_cnt - base >= n) break;
    end
    if (k == 20000) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: got %0d expected %0d samples", hs_cnt - base, n);
    end
  endtask

  task automatic run_seq(input int len, input int dut_num, input int model_nseq,
                         input logic [15:0] amp, input int guard, input int pct,
                         input int stop_at, input int rst_at);
    int          g, base, dc0, k;
    logic [15:0] a, pos, neg;
    item_t       it;
`ifdef PNSEQ_FRAMER_GUARD_EN
    g = guard;
`else
    g = 0;
`endif
    a   = amp & 16'h7fff;
    pos = a;
    neg = ~a + 16'd1;
    exp_q.delete();
    for (int s = 0; s < model_nseq; s++) begin
      for (int c = 0; c < len; c++) begin
        it.data   = {pn[c % 63] ? pos : neg, 16'h0000};
        it.last   = (c == len - 1);
        it.bubble = (c == len - 1) && (s != model_nseq - 1) && (g == 0);
        exp_q.push_back(it);
      end
      if (s != model_nseq - 1)
        for (int z = 0; z < g; z++) begin
          it.data   = '0;
          it.last   = 1'b0;
          it.bubble = (z == g - 1);
          exp_q.push_back(it);
        end
    end
    @(posedge clk);
    #1;
    ready_pct = pct;
    first_hs  = 1'b1;
    en_cnt    = 0;
    ld_cnt    = 0;
    base      = hs_cnt;
    dc0       = done_cnt;
    cfg_start = 1'b1;
    cfg_seq_len = 16'(len);
    cfg_num_seq = 16'(dut_num);
    cfg_amp     = amp;
    cfg_guard   = 16'(guard);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    check("lat_load", 64'(lfsr_load), 1);
    check("lat_busy", 64'(busy), 1);
    cfg_seq_len = 16'($urandom);
    cfg_num_seq = 16'($urandom);
    cfg_amp     = 16'($urandom);
    cfg_guard   = 16'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    check("lat_load_off", 64'(lfsr_load), 0);
    check("lat_novalid", 64'(axis.tvalid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(axis.tvalid), 1);
    if (stop_at > 0) begin
      wait_hs(base, stop_at);
      #1;
      cfg_stop    = 1'b1;
      cfg_start   = 1'b1;
      cfg_seq_len = 16'd5;
      @(posedge clk);
      #1;
      cfg_stop  = 1'b0;
      cfg_start = 1'b0;
    end
    if (rst_at > 0) begin
      wait_hs(base, rst_at);
      #2 rst = 1'b0;
      #1;
      check("rst_tvalid", 64'(axis.tvalid), 0);
      check("rst_tdata", 64'(axis.tdata), 0);
      check("rst_tlast", 64'(axis.tlast), 0);
      check("rst_load", 64'(lfsr_load), 0);
      check("rst_en", 64'(lfsr_en), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) begin
        @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 0);
        check("post_rst_done", 64'(done), 0);
      end
      return;
    end
    for (k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (done_cnt != dc0) break;
    end
    if (k == 20000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d remaining expected 0", exp_q.size());
    end
    check("queue_drained", 64'(exp_q.size()), 0);
    check("lfsr_en_count", 64'(en_cnt), 64'(len * model_nseq));
    check("lfsr_load_count", 64'(ld_cnt), 64'(model_nseq));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int ones;
    // Pin the reference m-sequence with hand-derived values.
    ones = 0;
    for (int n = 0; n < 63; n++) ones += int'(pn[n]);
    check("pn_ones", 64'(ones), 32);
    check("pn0", 64'(pn[0]), 0);
    check("pn5", 64'(pn[5]), 1);
    check("pn10", 64'(pn[10]), 1);
    check("pn11", 64'(pn[11]), 1);
    check("pn68", 64'(pn[68]), 1);

    #3;
    check("reset_tvalid", 64'(axis.tvalid), 0);
    check("reset_tdata", 64'(axis.tdata), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_load", 64'(lfsr_load), 0);
    check("reset_done", 64'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Start with zero length must be ignored.
    @(posedge clk);
    #1;
    cfg_start   = 1'b1;
    cfg_seq_len = 16'd0;
    cfg_num_seq = 16'd1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    check("zero_len_busy", 64'(busy), 0);
    check("zero_len_load", 64'(lfsr_load), 0);

    run_seq(63, 1, 1, 16'h4000, 0, 100, 0, 0);
    run_seq(63, 3, 3, 16'h4000, 0, 100, 0, 0);
    run_seq(63, 1, 1, 16'h4000, 0, 50, 0, 0);
    run_seq(63, 0, 2, 16'h4000, 0, 100, 63 + 10, 0);
    run_seq(63, 2, 2, 16'h4000, 0, 100, 0, 30);
    run_seq(63, 1, 1, 16'h4000, 0, 100, 0, 0);
`ifdef PNSEQ_FRAMER_GUARD_EN
    run_seq(63, 2, 2, 16'h4000, 4, 100, 0, 0);
`endif
    for (int r = 0; r < 8; r++) begin
      int len, nseq;
      len  = $urandom_range(1, 70);
      nseq = $urandom_range(1, 3);
      run_seq(len, nseq, nseq, 16'($urandom), $urandom_range(0, 3),
              $urandom_range(30, 100), 0, 0);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
